// File: rtl/ssd_scan_driver_pkg.sv
// Shared constants for the multiplexed 7-segment scan driver.
// Segment codes are active-low, ordered {g,f,e,d,c,b,a}.
package ssd_scan_driver_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h40;
    localparam seg_t SEG_1    = 7'h79;
    localparam seg_t SEG_2    = 7'h24;
    localparam seg_t SEG_3    = 7'h30;
    localparam seg_t SEG_4    = 7'h19;
    localparam seg_t SEG_5    = 7'h12;
    localparam seg_t SEG_6    = 7'h02;
    localparam seg_t SEG_7    = 7'h78;
    localparam seg_t SEG_8    = 7'h00;
    localparam seg_t SEG_9    = 7'h10;
    localparam seg_t SEG_DASH = 7'h3F;
    localparam seg_t SEG_OFF  = 7'h7F;

    localparam logic AN_OFF = 1'b1;
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/ssd_scan_driver_bcd_to_7seg.sv
// Combinational BCD nibble to active-low segment decoder.
// Codes outside 0..9 show a dash so corrupt digits are visible.
import ssd_scan_driver_pkg::*;

module bcd_to_7seg (
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (nib_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// Time-multiplexed common-anode display driver with frame snapshot,
// leading-zero blanking and registered active-low outputs.
import ssd_scan_driver_pkg::*;

module ssd_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank_lz,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int REF_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    tick_q, tick_d;

    logic                    ref_wrap;
    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS-1:0]   nz;
    logic                    upper_zero;

    bcd_to_7seg u_dec (
        .nib_i (cur_nib),
        .seg_o (dec_seg)
    );

    always_comb begin
        ref_wrap  = (ref_cnt_q == REF_LAST);
        frame_end = ref_wrap && (idx_q == IDX_LAST);
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
        idx_d     = idx_q;
        if (ref_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Shadow copies are only refreshed at the frame boundary to avoid tearing.
    always_comb begin
        shadow_d    = shadow_q;
        shadow_dp_d = shadow_dp_q;
        if (frame_end) begin
            shadow_d    = digits;
            shadow_dp_d = dp_in;
        end
    end

    always_comb begin
        nz = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nz[i] = |shadow_q[4*i +: 4];
        end
        upper_zero = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (i >= int'(idx_q) && nz[i]) begin
                upper_zero = 1'b0;
            end
        end
    end

    assign cur_nib = shadow_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        an_d   = ~(NUM_DIGITS'(1) << idx_q);
        seg_d  = dec_seg;
        dp_d   = ~shadow_dp_q[idx_q];
        tick_d = frame_end;
        if (blank_lz && (idx_q != '0) && upper_zero) begin
            seg_d = SEG_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ref_cnt_q   <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            shadow_dp_q <= '0;
            an_q        <= {NUM_DIGITS{AN_OFF}};
            seg_q       <= SEG_OFF;
            dp_q        <= DP_OFF;
            tick_q      <= 1'b0;
        end else begin
            ref_cnt_q   <= ref_cnt_d;
            idx_q       <= idx_d;
            shadow_q    <= shadow_d;
            shadow_dp_q <= shadow_dp_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            tick_q      <= tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: expected digit windows are queued
// by the stimulus and checked by a monitor whenever the anode pattern changes.
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    always #5 clk = ~clk;

    ssd_scan_driver #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .digits     (digits),
        .dp_in      (dp_in),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int   errs = 0;
    int   checks = 0;
    int   ecount = -1;
    int   ticks = 0;

    task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d);
        q.push_back(exp_t'{a, s, d, 1'b0});
    endtask

    task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3,
                              input logic [3:0] dpl);
        logic [6:0] s [4];
        logic [3:0] a;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int i = 0; i < 4; i++) begin
            a = ~(4'b0001 << i);
            push(a, s[i], ~dpl[i]);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ecount++;
        end
    endtask

    task automatic go(input int e);
        step(e - ecount);
    endtask

    int         cyc = 0;
    logic [3:0] prev_an = 4'bxxxx;
    int         last_evt = -1;
    int         last_tick = -1;
    int         rel_start = -1;

    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        cyc++;
        act = {an, seg, dp, frame_tick};
        if (an !== prev_an) begin
            checks++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_output: got an=%b seg=%h dp=%b tick=%b, required no change",
                         an, seg, dp, frame_tick);
            end else begin
                e = q.pop_front();
                if (act !== e) begin
                    errs++;
                    $display("FAIL digit_window @%0d: got an=%b seg=%h dp=%b tick=%b, required an=%b seg=%h dp=%b tick=%b",
                             cyc, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
                end
            end
            if (!$isunknown(prev_an) && prev_an !== 4'hF && an !== 4'hF) begin
                checks++;
                if (cyc - last_evt != RD) begin
                    errs++;
                    $display("FAIL dwell @%0d: got %0d cycles, required %0d", cyc, cyc - last_evt, RD);
                end
            end
            if (prev_an === 4'hF) rel_start = cyc;
            if (an === 4'hF) last_tick = -1;
            last_evt = cyc;
            prev_an = an;
        end
        if (frame_tick === 1'b1) begin
            ticks++;
            checks++;
            if (last_tick >= 0) begin
                if (cyc - last_tick != ND * RD) begin
                    errs++;
                    $display("FAIL tick_period @%0d: got %0d, required %0d", cyc, cyc - last_tick, ND * RD);
                end
            end else if (cyc - rel_start != ND * RD - 1) begin
                errs++;
                $display("FAIL first_tick @%0d: got %0d after scan start, required %0d",
                         cyc, cyc - rel_start, ND * RD - 1);
            end
            last_tick = cyc;
        end
    end

    initial begin
        rst = 1'b1;
        digits = 16'h1234;
        push(4'hF, 7'h7F, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ecount = -1;
        // Frame 0 shows the reset shadow; frames 1-2 show 1234.
        push_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0000);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        push_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'b0000);
        go(36);
        digits = 16'h5678;
        push_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'b0000);
        go(50);
        digits = 16'h0007;
        blank_lz = 1'b1;
        push_frame(7'h78, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        go(66);
        digits = 16'h0000;
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        go(82);
        digits = 16'h0105;
        push_frame(7'h12, 7'h40, 7'h79, 7'h7F, 4'b0000);
        go(98);
        digits = 16'h00A0;
        dp_in = 4'b0100;
        push_frame(7'h40, 7'h3F, 7'h7F, 7'h7F, 4'b0100);
        push(4'b1110, 7'h40, 1'b1);
        push(4'b1101, 7'h3F, 1'b1);
        push(4'b1011, 7'h7F, 1'b0);
        go(136);
        rst = 1'b1;
        push(4'hF, 7'h7F, 1'b1);
        step(1);
        rst = 1'b0;
        ecount = -1;
        push_frame(7'h40, 7'h7F, 7'h7F, 7'h7F, 4'b0000);
        push_frame(7'h40, 7'h3F, 7'h7F, 7'h7F, 4'b0100);
        go(30);
        #6;
        checks++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL leftover_expect: got %0d pending, required 0", q.size());
        end
        checks++;
        if (ticks != 9) begin
            errs++;
            $display("FAIL tick_count: got %0d, required 9", ticks);
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
